dfd_trace_sink_buf: RTL and testbench
=====================================

DFD_TRACE_SINK_BUF -- requirements
Module: dfd_trace_sink_buf

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 64, meaning the trace word width in bits.
REQ-002 The block SHALL have parameter INDEX_WIDTH, default 9, meaning the per-bank index width (bank depth 2^INDEX_WIDTH).
REQ-003 The block SHALL have parameter NUM_BANKS, default 8, meaning the bank count; it SHALL be a power of two and at least 2.
REQ-004 The block SHALL use derived constants BW=log2(NUM_BANKS), AW=INDEX_WIDTH+BW and DEPTH=NUM_BANKS*2^INDEX_WIDTH.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL be on its rising edge.
REQ-006 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port i_enable, input, 1 bit: capture enable.
REQ-008 The block SHALL have port i_wrap_mode, input, 1 bit: 1 selects circular capture, 0 selects stop-on-full.
REQ-009 The block SHALL have port i_clear, input, 1 bit: single-cycle pulse that clears capture state.
REQ-010 The block SHALL have ports i_trc_valid (input, 1), o_trc_ready (output, 1) and i_trc_data (input, DATA_WIDTH): the trace write handshake.
REQ-011 The block SHALL have ports i_rd_req (input, 1), i_rd_addr (input, AW) and o_rd_gnt (output, 1): the readback request.
REQ-012 The block SHALL have ports o_rd_valid (output, 1) and o_rd_data (output, DATA_WIDTH): the readback response.
REQ-013 The block SHALL have port o_wptr, output, AW bits: the next write address.
REQ-014 The block SHALL have ports o_wrapped (output, 1), o_full (output, 1) and o_drop_cnt (output, 16): the capture status.

Function
REQ-015 Storage SHALL be NUM_BANKS single-port banks of 2^INDEX_WIDTH x DATA_WIDTH, each doing at most one access (read or write) per cycle.
REQ-016 For any address A, the bank SHALL be A[BW-1:0] and the index SHALL be A[AW-1:BW], so consecutive words interleave across banks.
REQ-017 o_trc_ready SHALL equal i_enable & ~i_clear, combinationally; the block SHALL never apply backpressure for full.
REQ-018 An accepted beat (i_trc_valid & o_trc_ready) with o_full=0 SHALL write i_trc_data at o_wptr, and o_wptr SHALL advance by 1 modulo DEPTH on the next cycle.
REQ-019 An accepted beat with o_full=1 SHALL not write, SHALL hold o_wptr, and SHALL increment o_drop_cnt, saturating at 16'hFFFF.
REQ-020 A write at o_wptr=DEPTH-1 with i_wrap_mode=1 SHALL set o_wrapped, which is sticky until clear or reset; o_wptr SHALL become 0.
REQ-021 A write at o_wptr=DEPTH-1 with i_wrap_mode=0 SHALL set o_full, which is sticky; o_wptr SHALL become 0.
REQ-022 i_wrap_mode SHALL be sampled per write; changing it mid-capture SHALL not alter the existing o_full or o_wrapped state.
REQ-023 o_rd_gnt SHALL equal i_rd_req & ~(accepted write this cycle to bank i_rd_addr[BW-1:0]), so writes win bank conflicts.
REQ-024 The requester SHALL hold i_rd_req and i_rd_addr stable until o_rd_gnt; the block SHALL not queue reads.
REQ-025 A grant in cycle N SHALL give o_rd_valid=1 for exactly cycle N+1, with o_rd_data equal to the bank contents at cycle N.
REQ-026 o_rd_data SHALL hold its value until the next o_rd_valid.
REQ-027 A read and a write to the same address in one cycle SHALL not occur (REQ-023); a read and a write to different banks in one cycle SHALL both complete.
REQ-028 i_clear SHALL set o_wptr=0, o_wrapped=0, o_full=0 and o_drop_cnt=0 on the next cycle, leave memory contents unchanged, and permit reads.
REQ-029 With i_enable=0, all capture state SHALL hold.

Reset
REQ-030 While reset_n=0, all outputs SHALL be 0 (o_trc_ready is 0 while i_enable=0), and an in-flight read SHALL be discarded.
REQ-031 Memory contents SHALL not be reset; reading unwritten locations SHALL return undefined data.
REQ-032 After reset_n rises, the block SHALL accept beats on the first edge where o_trc_ready=1.

Verification (NUM_BANKS=2, INDEX_WIDTH=2, DEPTH=8)
REQ-033 A bench SHALL cover: wrap mode, 10 beats 0x100..0x109 -> o_wptr=2, o_wrapped=1, o_full=0; addresses 0..1 read 0x108/0x109 and addresses 2..7 read 0x102..0x107.
REQ-034 A bench SHALL cover: stop mode, 11 beats -> o_full=1 after the 8th beat, o_drop_cnt=3, o_wptr=0, and addresses 0..7 hold beats 0..7.
REQ-035 A bench SHALL cover: read address 3 in the same cycle as a write to address 5 (same bank 1) -> o_rd_gnt=0; the next idle cycle -> o_rd_gnt=1 and o_rd_valid=1 one cycle later.
REQ-036 A bench SHALL cover: read address 2 in the same cycle as a write to address 5 -> both complete, and o_rd_valid appears at N+1.
REQ-037 A bench SHALL cover: i_clear asserted together with i_trc_valid when full -> o_trc_ready=0, and the next cycle o_wptr=0, o_full=0, o_drop_cnt=0, with memory intact.
REQ-038 A bench SHALL cover: reset_n=0 asserted mid-capture with a read pending -> all outputs 0 immediately, and no o_rd_valid after release.

Source files
------------

// File: rtl/dfd_trace_sink_buf_if.sv
// Trace write handshake and readback request/response bundle for the trace sink buffer.
interface dfd_trace_sink_buf_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned AW         = 12
);
    logic                  i_trc_valid;
    logic                  o_trc_ready;
    logic [DATA_WIDTH-1:0] i_trc_data;
    logic                  i_rd_req;
    logic [AW-1:0]         i_rd_addr;
    logic                  o_rd_gnt;
    logic                  o_rd_valid;
    logic [DATA_WIDTH-1:0] o_rd_data;

    // Trace source / readback requester side
    modport master (
        output i_trc_valid, i_trc_data, i_rd_req, i_rd_addr,
        input  o_trc_ready, o_rd_gnt, o_rd_valid, o_rd_data
    );

    // Buffer side
    modport slave (
        input  i_trc_valid, i_trc_data, i_rd_req, i_rd_addr,
        output o_trc_ready, o_rd_gnt, o_rd_valid, o_rd_data
    );
endinterface

// File: rtl/dfd_trace_sink_buf.sv
// Banked trace capture buffer: circular or stop-on-full capture of trace beats,
// word-interleaved across single-port banks, with a conflict-arbitrated readback port.
module dfd_trace_sink_buf #(
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned INDEX_WIDTH = 9,
    parameter int unsigned NUM_BANKS   = 8,
    localparam int unsigned BW         = $clog2(NUM_BANKS),
    localparam int unsigned AW         = INDEX_WIDTH + BW
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_enable,
    input  logic                 i_wrap_mode,
    input  logic                 i_clear,
    dfd_trace_sink_buf_if.slave  bus,
    output logic [AW-1:0]        o_wptr,
    output logic                 o_wrapped,
    output logic                 o_full,
    output logic [15:0]          o_drop_cnt
);
    localparam int unsigned BANK_DEPTH = 1 << INDEX_WIDTH;

    if (NUM_BANKS < 2 || (NUM_BANKS & (NUM_BANKS - 1)) != 0) begin : g_bad_banks
        $error("NUM_BANKS must be a power of two and at least 2");
    end

    logic [AW-1:0]          wptr_q, wptr_d;
    logic                   wrapped_q, wrapped_d;
    logic                   full_q, full_d;
    logic [15:0]            drop_q, drop_d;
    logic                   rd_valid_q;
    logic [DATA_WIDTH-1:0]  rd_data_q;

    logic                   trc_ready;
    logic                   accept;
    logic                   wr_en;
    logic                   rd_gnt;
    logic [BW-1:0]          wr_bank, rd_bank;
    logic [INDEX_WIDTH-1:0] wr_idx, rd_idx;
    logic [DATA_WIDTH-1:0]  bank_rdata [NUM_BANKS];

    assign wr_bank = wptr_q[BW-1:0];
    assign wr_idx  = wptr_q[AW-1:BW];
    assign rd_bank = bus.i_rd_addr[BW-1:0];
    assign rd_idx  = bus.i_rd_addr[AW-1:BW];

    // Ready is never withheld for full; held low in reset so every output reads 0.
    assign trc_ready = reset_n & i_enable & ~i_clear;
    assign accept    = bus.i_trc_valid & trc_ready;
    assign wr_en     = accept & ~full_q;
    // A real write owns its bank this cycle; a read to that bank must retry.
    assign rd_gnt    = reset_n & bus.i_rd_req & ~(wr_en & (wr_bank == rd_bank));

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        localparam logic [BW-1:0] BANK_ID = BW'(b);
        logic [DATA_WIDTH-1:0] mem [BANK_DEPTH];

        // Bank storage write port; contents are deliberately not reset.
        always_ff @(posedge clk) begin
            if (wr_en && (wr_bank == BANK_ID)) begin
                mem[wr_idx] <= bus.i_trc_data;
            end
        end

        assign bank_rdata[b] = mem[rd_idx];
    end

    // Next capture state: clear wins, dropped beats only count, writes advance the pointer.
    always_comb begin
        wptr_d    = wptr_q;
        wrapped_d = wrapped_q;
        full_d    = full_q;
        drop_d    = drop_q;
        if (i_clear) begin
            wptr_d    = '0;
            wrapped_d = 1'b0;
            full_d    = 1'b0;
            drop_d    = '0;
        end else if (accept) begin
            if (full_q) begin
                if (drop_q != '1) begin
                    drop_d = drop_q + 16'd1;
                end
            end else begin
                wptr_d = wptr_q + AW'(1);
                if (wptr_q == '1) begin
                    if (i_wrap_mode) begin
                        wrapped_d = 1'b1;
                    end else begin
                        full_d = 1'b1;
                    end
                end
            end
        end
    end

    // Capture status and readback response registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q     <= '0;
            wrapped_q  <= 1'b0;
            full_q     <= 1'b0;
            drop_q     <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            wptr_q     <= wptr_d;
            wrapped_q  <= wrapped_d;
            full_q     <= full_d;
            drop_q     <= drop_d;
            rd_valid_q <= rd_gnt;
            if (rd_gnt) begin
                rd_data_q <= bank_rdata[rd_bank];
            end
        end
    end

    assign bus.o_trc_ready = trc_ready;
    assign bus.o_rd_gnt    = rd_gnt;
    assign bus.o_rd_valid  = rd_valid_q;
    assign bus.o_rd_data   = rd_data_q;
    assign o_wptr          = wptr_q;
    assign o_wrapped       = wrapped_q;
    assign o_full          = full_q;
    assign o_drop_cnt      = drop_q;
endmodule

// File: tb/tb_dfd_trace_sink_buf.sv
// Self-checking bench for dfd_trace_sink_buf: directed scenarios with literal
// expectations plus a randomized phase checked every cycle against a behavioural model.
module tb_dfd_trace_sink_buf;
    localparam int unsigned DW    = 16;
    localparam int unsigned IW    = 2;
    localparam int unsigned NB    = 2;
    localparam int unsigned AW    = 3;
    localparam int unsigned DEPTH = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic en = 1'b0, wrap = 1'b0, clr = 1'b0;
    logic [AW-1:0] wptr;
    logic wrapped, full;
    logic [15:0] drop;

    int total = 0;
    int bad   = 0;

    dfd_trace_sink_buf_if #(.DATA_WIDTH(DW), .AW(AW)) bus ();

    dfd_trace_sink_buf #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW), .NUM_BANKS(NB)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_enable    (en),
        .i_wrap_mode (wrap),
        .i_clear     (clr),
        .bus         (bus),
        .o_wptr      (wptr),
        .o_wrapped   (wrapped),
        .o_full      (full),
        .o_drop_cnt  (drop)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_wr [DEPTH];
    int            m_wptr = 0;
    bit            m_full = 0, m_wrapped = 0;
    int            m_drop = 0;
    bit            m_rv = 0;
    logic [DW-1:0] m_rd = '0;
    bit            m_rd_known = 1;
    bit            m_gnt_last = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Model update: one step of the buffer's rules per clock, immediate on reset.
    always @(posedge clk or negedge reset_n) begin : model
        bit acc, wr, gnt;
        int a;
        if (!reset_n) begin
            m_wptr = 0; m_full = 0; m_wrapped = 0; m_drop = 0;
            m_rv = 0; m_rd = '0; m_rd_known = 1; m_gnt_last = 0;
        end else begin
            acc = bus.i_trc_valid && en && !clr;
            wr  = acc && !m_full;
            a   = int'(bus.i_rd_addr);
            gnt = bus.i_rd_req && !(wr && ((m_wptr % NB) == (a % NB)));
            m_gnt_last = gnt;
            m_rv = gnt;
            if (gnt) begin
                m_rd = m_mem[a];
                m_rd_known = m_wr[a];
            end
            if (clr) begin
                m_wptr = 0; m_full = 0; m_wrapped = 0; m_drop = 0;
            end else if (acc) begin
                if (m_full) begin
                    if (m_drop < 65535) m_drop++;
                end else begin
                    m_mem[m_wptr] = bus.i_trc_data;
                    m_wr[m_wptr] = 1;
                    if (m_wptr == DEPTH - 1) begin
                        if (wrap) m_wrapped = 1; else m_full = 1;
                    end
                    m_wptr = (m_wptr + 1) % DEPTH;
                end
            end
        end
    end

    // Compare process: every cycle, mid-period, DUT outputs against the model.
    always @(negedge clk) begin : compare
        bit e_ready, e_wr, e_gnt;
        e_ready = reset_n && en && !clr;
        e_wr    = e_ready && bus.i_trc_valid && !m_full;
        e_gnt   = reset_n && bus.i_rd_req &&
                  !(e_wr && ((m_wptr % NB) == (int'(bus.i_rd_addr) % NB)));
        chk("m_ready",   32'(bus.o_trc_ready), 32'(e_ready));
        chk("m_gnt",     32'(bus.o_rd_gnt),    32'(e_gnt));
        chk("m_wptr",    32'(wptr),            32'(m_wptr));
        chk("m_full",    32'(full),            32'(m_full));
        chk("m_wrapped", 32'(wrapped),         32'(m_wrapped));
        chk("m_drop",    32'(drop),            32'(m_drop));
        chk("m_rvalid",  32'(bus.o_rd_valid),  32'(m_rv));
        if (m_rd_known) chk("m_rdata", 32'(bus.o_rd_data), 32'(m_rd));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [DW-1:0] d);
        bus.i_trc_valid = 1'b1;
        bus.i_trc_data  = d;
        tick();
        bus.i_trc_valid = 1'b0;
    endtask

    task automatic clear_pulse();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic rd_check(input int a, input logic [DW-1:0] exp);
        bit g;
        g = 0;
        bus.i_rd_req  = 1'b1;
        bus.i_rd_addr = AW'(a);
        for (int n = 0; n < 10 && !g; n++) begin
            @(negedge clk);
            g = bus.o_rd_gnt;
            tick();
        end
        bus.i_rd_req = 1'b0;
        chk("rd_grant_seen", 32'(g), 32'd1);
        chk("rd_valid_n1",   32'(bus.o_rd_valid), 32'd1);
        chk("rd_data",       32'(bus.o_rd_data),  32'(exp));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "timeout");
    end

    initial begin : stim
        bus.i_trc_valid = 1'b0;
        bus.i_trc_data  = '0;
        bus.i_rd_req    = 1'b0;
        bus.i_rd_addr   = '0;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_wptr",    32'(wptr),           32'd0);
        chk("rst_full",    32'(full),           32'd0);
        chk("rst_wrapped", 32'(wrapped),        32'd0);
        chk("rst_drop",    32'(drop),           32'd0);
        chk("rst_rvalid",  32'(bus.o_rd_valid), 32'd0);
        chk("rst_ready",   32'(bus.o_trc_ready), 32'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        tick();

        // Circular capture: 10 beats into 8 words
        en = 1'b1; wrap = 1'b1;
        for (int i = 0; i < 10; i++) beat(DW'(16'h100 + i));
        chk("wrap_wptr",    32'(wptr),    32'd2);
        chk("wrap_wrapped", 32'(wrapped), 32'd1);
        chk("wrap_full",    32'(full),    32'd0);
        for (int a = 0; a < 8; a++)
            rd_check(a, (a < 2) ? DW'(16'h108 + a) : DW'(16'h100 + a));

        // Stop-on-full: 11 beats, last 3 dropped
        wrap = 1'b0;
        clear_pulse();
        for (int i = 0; i < 11; i++) begin
            beat(DW'(16'h200 + i));
            if (i == 7) begin
                chk("stop_full_at8", 32'(full), 32'd1);
                chk("stop_wptr_at8", 32'(wptr), 32'd0);
                chk("stop_drop_at8", 32'(drop), 32'd0);
            end
        end
        chk("stop_drop", 32'(drop), 32'd3);
        chk("stop_wptr", 32'(wptr), 32'd0);
        chk("stop_full", 32'(full), 32'd1);
        for (int a = 0; a < 8; a++) rd_check(a, DW'(16'h200 + a));

        // Same-bank conflict: read 3 while writing 5
        wrap = 1'b1;
        clear_pulse();
        for (int i = 0; i < 5; i++) beat(DW'(16'h300 + i));
        bus.i_trc_valid = 1'b1; bus.i_trc_data = 16'h305;
        bus.i_rd_req = 1'b1; bus.i_rd_addr = 3'd3;
        @(negedge clk);
        chk("conf_gnt_blocked", 32'(bus.o_rd_gnt), 32'd0);
        tick();
        bus.i_trc_valid = 1'b0;
        @(negedge clk);
        chk("conf_gnt_idle", 32'(bus.o_rd_gnt), 32'd1);
        tick();
        bus.i_rd_req = 1'b0;
        chk("conf_rvalid", 32'(bus.o_rd_valid), 32'd1);
        chk("conf_rdata",  32'(bus.o_rd_data),  32'h303);

        // Different banks: read 2 while writing 5
        clear_pulse();
        for (int i = 0; i < 5; i++) beat(DW'(16'h400 + i));
        bus.i_trc_valid = 1'b1; bus.i_trc_data = 16'h405;
        bus.i_rd_req = 1'b1; bus.i_rd_addr = 3'd2;
        @(negedge clk);
        chk("par_gnt", 32'(bus.o_rd_gnt), 32'd1);
        tick();
        bus.i_trc_valid = 1'b0; bus.i_rd_req = 1'b0;
        chk("par_rvalid", 32'(bus.o_rd_valid), 32'd1);
        chk("par_rdata",  32'(bus.o_rd_data),  32'h402);
        chk("par_wptr",   32'(wptr),           32'd6);
        rd_check(5, 16'h405);

        // Clear while full with a beat offered
        wrap = 1'b0;
        clear_pulse();
        for (int i = 0; i < 8; i++) beat(DW'(16'h500 + i));
        chk("clr_pre_full", 32'(full), 32'd1);
        beat(16'h5ff);
        chk("clr_pre_drop", 32'(drop), 32'd1);
        clr = 1'b1; bus.i_trc_valid = 1'b1; bus.i_trc_data = 16'h5aa;
        @(negedge clk);
        chk("clr_ready", 32'(bus.o_trc_ready), 32'd0);
        tick();
        clr = 1'b0; bus.i_trc_valid = 1'b0;
        chk("clr_wptr", 32'(wptr), 32'd0);
        chk("clr_full", 32'(full), 32'd0);
        chk("clr_drop", 32'(drop), 32'd0);
        rd_check(3, 16'h503);
        rd_check(7, 16'h507);

        // Reset mid-capture with a read in flight
        wrap = 1'b1;
        for (int i = 0; i < 3; i++) beat(DW'(16'h600 + i));
        bus.i_trc_valid = 1'b1; bus.i_trc_data = 16'h603;
        bus.i_rd_req = 1'b1; bus.i_rd_addr = 3'd6;
        @(negedge clk);
        chk("rr_gnt", 32'(bus.o_rd_gnt), 32'd1);
        tick();
        reset_n = 1'b0;
        #1;
        chk("rr_wptr",    32'(wptr),            32'd0);
        chk("rr_full",    32'(full),            32'd0);
        chk("rr_wrapped", 32'(wrapped),         32'd0);
        chk("rr_drop",    32'(drop),            32'd0);
        chk("rr_rvalid",  32'(bus.o_rd_valid),  32'd0);
        chk("rr_rdata",   32'(bus.o_rd_data),   32'd0);
        chk("rr_ready",   32'(bus.o_trc_ready), 32'd0);
        chk("rr_gnt0",    32'(bus.o_rd_gnt),    32'd0);
        bus.i_trc_valid = 1'b0; bus.i_rd_req = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rr_no_rvalid", 32'(bus.o_rd_valid), 32'd0);
        end

        // Randomized phase
        for (int c = 0; c < 3000; c++) begin
            if (bus.i_rd_req && m_gnt_last) bus.i_rd_req = 1'b0;
            if (!bus.i_rd_req && $urandom_range(0, 99) < 40) begin
                bus.i_rd_req  = 1'b1;
                bus.i_rd_addr = AW'($urandom_range(0, DEPTH - 1));
            end
            en   = ($urandom_range(0, 99) < 92);
            if ($urandom_range(0, 99) < 3) wrap = ~wrap;
            clr  = ($urandom_range(0, 99) < 2);
            bus.i_trc_valid = ($urandom_range(0, 99) < 60);
            bus.i_trc_data  = DW'($urandom);
            if ($urandom_range(0, 999) < 2) begin
                reset_n = 1'b0;
                #1 reset_n = 1'b1;
            end
            tick();
        end
        bus.i_trc_valid = 1'b0; bus.i_rd_req = 1'b0; clr = 1'b0;
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
